// File: rtl/key_conditioner_if.sv
// key_conditioner_if: key-input bundle between the button front end and the watch core.
//   KEY_RAW   : raw button levels, 1 = pressed, asynchronous to the clock
//   KEY_LEVEL : debounced key levels
//   KEY_PULSE : one-cycle pulse per accepted press and per auto-repeat
//   KEY_CODE  : index of the reported key event (lowest pulsing key)
//   KEY_VALID : qualifies KEY_CODE for one cycle
// Modports: master drives KEY_RAW and observes the conditioned keys; slave is the conditioner.
interface key_conditioner_if #(
    parameter int unsigned N_KEYS = 10
);
    logic [N_KEYS-1:0] KEY_RAW;
    logic [N_KEYS-1:0] KEY_LEVEL;
    logic [N_KEYS-1:0] KEY_PULSE;
    logic [3:0]        KEY_CODE;
    logic              KEY_VALID;

    modport master (
        output KEY_RAW,
        input  KEY_LEVEL,
        input  KEY_PULSE,
        input  KEY_CODE,
        input  KEY_VALID
    );

    modport slave (
        input  KEY_RAW,
        output KEY_LEVEL,
        output KEY_PULSE,
        output KEY_CODE,
        output KEY_VALID
    );
endinterface

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises and debounces raw push-button levels, emits one-cycle press
// pulses, auto-repeats a held key from REPEAT_MASK and encodes the lowest pulsing key.
// Ports:
//   CLK_1k : system clock (1 kHz)
//   RESET  : asynchronous active-low reset
//   kc     : key bundle (slave) - KEY_RAW in; KEY_LEVEL, KEY_PULSE, KEY_CODE, KEY_VALID out
// Pipeline: sync (2 flops) -> debounced level lvl_q -> registered outputs. The repeat engine
// acts on lvl_q transitions; its fire is staged through rep_q so repeat pulses line up with
// press pulses on the output register.
module key_conditioner #(
    parameter int unsigned       N_KEYS      = 10,
    parameter int unsigned       DB_CYCLES   = 20,
    parameter int unsigned       HOLD_CYCLES = 500,
    parameter int unsigned       REP_CYCLES  = 100,
    parameter logic [N_KEYS-1:0] REPEAT_MASK = 10'b0000001111
) (
    input logic              CLK_1k,
    input logic              RESET,
    key_conditioner_if.slave kc
);

    localparam logic [7:0] DbLast   = 8'(DB_CYCLES - 1);
    localparam logic [9:0] HoldLast = 10'(HOLD_CYCLES - 1);
    localparam logic [9:0] RepLast  = 10'(REP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

    function automatic logic [3:0] lowest_idx(input logic [N_KEYS-1:0] v);
        logic [3:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (v[i] && !found) begin
                idx   = 4'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Synchroniser
    logic [N_KEYS-1:0] s1_q, s2_q;

    // Debouncer
    logic [7:0]        cnt_q [N_KEYS];
    logic [7:0]        cnt_d [N_KEYS];
    logic [N_KEYS-1:0] lvl_q, lvl_d;
    logic [N_KEYS-1:0] press, fall, masked_press;

    // Repeat engine
    state_e            state_q, state_d;
    logic [3:0]        trk_q, trk_d;
    logic [9:0]        rc_q, rc_d;
    logic [N_KEYS-1:0] rep_q, rep_d;

    // Output registers
    logic [N_KEYS-1:0] level_q, level_d;
    logic [N_KEYS-1:0] pulse_q, pulse_d;
    logic [3:0]        code_q, code_d;
    logic              valid_q, valid_d;

    always_comb begin
        lvl_d = lvl_q;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == DbLast) begin
                    lvl_d[i] = ~lvl_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign press        = lvl_d & ~lvl_q;
    assign fall         = lvl_q & ~lvl_d;
    assign masked_press = press & REPEAT_MASK;

    // Priority, lowest to highest: timed repeat, release of the tracked key, new masked press.
    always_comb begin
        state_d = state_q;
        trk_d   = trk_q;
        rc_d    = rc_q;
        rep_d   = '0;

        case (state_q)
            StHold: begin
                if (rc_q == HoldLast) begin
                    rep_d[trk_q] = 1'b1;
                    rc_d         = '0;
                    state_d      = StRepeat;
                end else begin
                    rc_d = rc_q + 10'd1;
                end
            end
            StRepeat: begin
                if (rc_q == RepLast) begin
                    rep_d[trk_q] = 1'b1;
                    rc_d         = '0;
                end else begin
                    rc_d = rc_q + 10'd1;
                end
            end
            default: begin
                rc_d = '0;
            end
        endcase

        if (state_q != StIdle && fall[trk_q]) begin
            state_d = StIdle;
            rc_d    = '0;
            rep_d   = '0;
        end

        if (|masked_press) begin
            trk_d   = lowest_idx(masked_press);
            state_d = StHold;
            rc_d    = '0;
            rep_d   = '0;
        end
    end

    always_comb begin
        level_d = lvl_q;
        pulse_d = (lvl_q & ~level_q) | rep_q;
        valid_d = |pulse_d;
        code_d  = code_q;
        if (valid_d) begin
            code_d = lowest_idx(pulse_d);
        end
    end

    always_ff @(posedge CLK_1k or negedge RESET) begin
        if (!RESET) begin
            s1_q    <= '0;
            s2_q    <= '0;
            cnt_q   <= '{default: '0};
            lvl_q   <= '0;
            state_q <= StIdle;
            trk_q   <= '0;
            rc_q    <= '0;
            rep_q   <= '0;
            level_q <= '0;
            pulse_q <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            s1_q    <= kc.KEY_RAW;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            state_q <= state_d;
            trk_q   <= trk_d;
            rc_q    <= rc_d;
            rep_q   <= rep_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign kc.KEY_LEVEL = level_q;
    assign kc.KEY_PULSE = pulse_q;
    assign kc.KEY_CODE  = code_q;
    assign kc.KEY_VALID = valid_q;

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Upstream input stage for the digital watch. It takes the raw, bouncing push-button levels that feed the watch's `NUM_INPUT` / `CHAR_INPUT` keys and produces debounced levels, single-cycle press pulses and an encoded key event, so the watch core only ever sees clean one-shot commands. It optionally auto-repeats held keys, so a held numeric key steps a time field continuously.

## Interface
- `N_KEYS`, 10: number of key inputs; bits [3:0] are the NUM keys and bits [9:4] are the CHAR keys.
- `DB_CYCLES`, 20: consecutive stable samples required to accept a level change (20 ms at 1 kHz); legal range 2..255.
- `HOLD_CYCLES`, 500: cycles from the initial press pulse to the first repeat pulse; legal range 2..1023.
- `REP_CYCLES`, 100: cycles between subsequent repeat pulses; legal range 2..1023.
- `REPEAT_MASK`, 10'b0000001111: keys allowed to auto-repeat.
- `CLK_1k`  in  1  system clock, 1 kHz.
- `RESET`  in  1  asynchronous, active-low reset.
- `KEY_RAW`  in  N_KEYS  raw button levels; 1 = pressed; asynchronous to the clock.
- `KEY_LEVEL`  out  N_KEYS  debounced key levels.
- `KEY_PULSE`  out  N_KEYS  one-cycle pulse on each accepted press and on each repeat.
- `KEY_CODE`  out  4  index of the reported key event.
- `KEY_VALID`  out  1  qualifies `KEY_CODE`; high for one cycle.

## Operation
- **Synchronizer:** each `KEY_RAW` bit passes through a 2-flop synchronizer (`s1`, `s2`).
- **Debounce, per key:** an 8-bit counter `cnt`.
  - If `s2 == KEY_LEVEL`: `cnt` ← 0.
  - Otherwise `cnt` increments. When `cnt == DB_CYCLES-1` and `s2` still differs, `KEY_LEVEL` toggles and `cnt` ← 0.
  - A glitch shorter than `DB_CYCLES` samples never changes `KEY_LEVEL`.
- **Press pulse:** `KEY_PULSE[i]` is high in the same cycle that `KEY_LEVEL[i]` goes 0→1. A release produces no pulse.
- **Repeat engine:** one shared FSM with states IDLE, HOLD and REPEAT. It has a tracked-key register `trk` (4 bits) and a 10-bit counter `rc`.
  - Any accepted press of a key in `REPEAT_MASK`: `trk` ← that key, `rc` ← 0, state → HOLD. This applies from any state, so the newest press steals tracking. If several such presses occur in one cycle, the lowest index is tracked.
  - HOLD: `rc` increments. At `rc == HOLD_CYCLES-1`: pulse `KEY_PULSE[trk]`, `rc` ← 0, state → REPEAT.
  - REPEAT: `rc` increments. At `rc == REP_CYCLES-1`: pulse `KEY_PULSE[trk]`, `rc` ← 0.
  - `KEY_LEVEL[trk]` falling in HOLD or REPEAT: state → IDLE with no pulse. This takes priority over a repeat pulse due in the same cycle.
  - A press of a key outside `REPEAT_MASK` does not disturb tracking.
- **Encoder:** when `KEY_PULSE` is nonzero, `KEY_VALID` = 1 and `KEY_CODE` = index of the lowest set bit of `KEY_PULSE`. Otherwise `KEY_VALID` = 0 and `KEY_CODE` holds its last value.
  - When pulses are simultaneous, all remain visible on `KEY_PULSE`; only the lowest index is encoded.
- **Outputs:** all outputs are registered; there are no combinational paths from `KEY_RAW`.

## Timing
- **Reset (`RESET` = 0):** applies immediately, asynchronously.
  - `KEY_LEVEL` = 0, `KEY_PULSE` = 0, `KEY_CODE` = 0, `KEY_VALID` = 0.
  - FSM = IDLE; all counters and synchronizer flops = 0.
- **Reset release:** a key already held at release is reported as a fresh press after the normal latency.
- **Reset mid-repeat:** the sequence is aborted and no pulse is emitted during or at the release of reset.
- **Press latency:** `KEY_RAW` rising before edge 0 and held gives `KEY_LEVEL`, `KEY_PULSE` and `KEY_VALID` high after edge `DB_CYCLES+2`, i.e. edge 22 at default parameters.
- **Release latency:** identical to press latency (`DB_CYCLES+2` edges).
- **Repeat timing:** the first repeat pulse comes `HOLD_CYCLES` cycles after the press pulse; later pulses are every `REP_CYCLES` cycles.
- **Pulse width:** every pulse is exactly one `CLK_1k` cycle. `KEY_VALID` coincides with `KEY_PULSE`.
- **Counter behaviour:** `rc` and `cnt` never wrap in legal operation. `rc` is cleared on every pulse and every state change.

## Test plan
- **Clean press:** `KEY_RAW[2]` held 1 from t=0 for 300 cycles → exactly one `KEY_PULSE[2]`, at edge 22, with `KEY_CODE` = 2 and `KEY_VALID` = 1; `KEY_LEVEL[2]` returns to 0 at edge 322.
- **Bounce:** `KEY_RAW[5]` toggles every 3 cycles for 30 cycles, then holds 1 → no pulse during bouncing; one pulse 22 cycles after the final rise.
- **Auto-repeat:** `KEY_RAW[1]` held 800 cycles → pulses at edges 22, 522 and 622, then every 100 cycles while held; release stops pulses with no extra pulse. The same stimulus on `KEY_RAW[8]` (not in `REPEAT_MASK`) → only the edge-22 pulse.
- **Simultaneous press:** `KEY_RAW[3]` and `KEY_RAW[1]` rise together → `KEY_PULSE` = 10'b0000001010 for one cycle, `KEY_CODE` = 1; repeat tracks key 1.
- **Tracking steal:** hold key 0; at cycle 300 also press key 2 → key 2 pulses at 322 and then repeats at 822 and 922; key 0 produces no repeats after 322.
- **Reset mid-repeat:** hold key 1, assert `RESET` low at cycle 550 for 5 cycles → all outputs 0 immediately; after release, a new press pulse at 22 cycles past the release edge.
